// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage core.
// Produces Mealy hold/flush controls for PC, IF/ID, ID/EX and EX/MEM from
// load-use, taken-branch and data-memory-wait conditions, and keeps
// saturating stall and redirect counters.
module pipeline_hazard_ctrl #(
  parameter int REDIRECT_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_hold,
  output logic             pc_sel_target,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_flush,
  output logic             exmem_hold,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;

  // rcnt counts the redirect cycles still owed after the branch cycle itself
  localparam logic [3:0] RCNT_INIT = 4'(REDIRECT_CYCLES - 1);

  state_t     state, state_nx;
  logic [3:0] rcnt, rcnt_nx;
  logic       redirect_acc;
  logic       memstall, loaduse;

  assign memstall = mem_req & ~mem_ready;
  assign loaduse  = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) |
                     (id_use_rs2 & (id_rs2 == ex_rd)));

  // Control outputs and next state from registered state plus current inputs
  always_comb begin
    pc_hold       = 1'b0;
    pc_sel_target = 1'b0;
    ifid_hold     = 1'b0;
    ifid_flush    = 1'b0;
    idex_hold     = 1'b0;
    idex_flush    = 1'b0;
    exmem_hold    = 1'b0;
    redirect_acc  = 1'b0;
    state_nx      = state;
    rcnt_nx       = rcnt;
    if (reset) begin
      // clear the front end while reset is applied
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_nx   = RUN;
      rcnt_nx    = 4'd0;
    end else begin
      case (state)
        // MEM_WAIT only differs from RUN in where it came from; once the
        // wait ends the same priority chain applies, so a branch parked in
        // EX during the wait is serviced on the exit cycle
        RUN, MEM_WAIT: begin
          if (memstall) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
            state_nx   = MEM_WAIT;
          end else if (ex_branch_taken) begin
            pc_sel_target = 1'b1;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            redirect_acc  = 1'b1;
            if (REDIRECT_CYCLES > 1) begin
              state_nx = REDIRECT;
              rcnt_nx  = RCNT_INIT;
            end else begin
              state_nx = RUN;
            end
          end else begin
            state_nx = RUN;
            if (loaduse) begin
              pc_hold    = 1'b1;
              ifid_hold  = 1'b1;
              idex_flush = 1'b1;
            end
          end
        end
        // keep squashing the latent fetch path; a memory wait freezes the
        // countdown and suppresses the flush so nothing in IF/ID is lost
        REDIRECT: begin
          if (memstall) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
          end else begin
            ifid_flush = 1'b1;
            rcnt_nx    = rcnt - 4'd1;
            if (rcnt == 4'd1) state_nx = RUN;
          end
        end
        default: state_nx = RUN;
      endcase
    end
  end

  // State and redirect countdown registers
  always_ff @(posedge clk) begin
    state <= state_nx;
    rcnt  <= rcnt_nx;
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if (pc_hold && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (redirect_acc && (redirect_count != '1))
        redirect_count <= redirect_count + CNT_W'(1);
    end
  end

endmodule
